// File: rtl/fifo_pkg.sv
// Shared definitions for the level-tracking byte queues (uart tx/rx, morse path).
//   level_bits()  : width of an occupancy counter able to hold 0..2**addr_bits
//   fifo_flags_t  : registered status flags carried together through the queue
//   FLAGS_RESET   : flag values after reset or flush (empty, below almost-empty)
package fifo_pkg;

    // One extra bit so a completely full queue (DEPTH) is representable.
    function automatic int unsigned level_bits(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:      1'b0,
        empty:     1'b1,
        afull:     1'b0,
        aempty:    1'b1,
        overflow:  1'b0,
        underflow: 1'b0
    };

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_level: DEPTH x WORD_BITS registers, synchronous write,
// asynchronous (combinational) read, no reset on the contents.
// Ports:
//   clk_i    write clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  word at raddr_i (combinational)
module fifo_mem #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WORD_BITS-1:0] mem_q [DEPTH];

    // Data path only: contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// Circular-buffer FIFO with occupancy count, programmable almost-full /
// almost-empty flags, sticky overflow/underflow and a synchronous flush.
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   clear_i      synchronous flush (wins over read/write in the same cycle)
//   write_i      write request, wdata_i pushed when accepted
//   wdata_i      write data
//   read_i       read request, pops the head word
//   rdata_o      head word (show-ahead), valid while empty_o = 0
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
//   afull_o      level_o >= AFULL_LEVEL
//   aempty_o     level_o <= AEMPTY_LEVEL
//   level_o      occupancy 0..DEPTH
//   overflow_o   sticky: write attempted while full (without a read)
//   underflow_o  sticky: read attempted while empty
module fifo_level
    import fifo_pkg::*;
#(
    parameter int unsigned WORD_BITS    = 8,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned AFULL_LEVEL  = 12,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 clear_i,
    input  logic                                 write_i,
    input  logic [WORD_BITS-1:0]                 wdata_i,
    input  logic                                 read_i,
    output logic [WORD_BITS-1:0]                 rdata_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 afull_o,
    output logic                                 aempty_o,
    output logic [level_bits(ADDR_BITS)-1:0]     level_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o
);

    localparam int unsigned DEPTH      = 1 << ADDR_BITS;
    localparam int unsigned LEVEL_BITS = level_bits(ADDR_BITS);

    // Elaboration-time parameter sanity checks.
    if (ADDR_BITS < 1) begin : g_bad_addr_bits
        $error("fifo_level: ADDR_BITS must be at least 1");
    end
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
        $error("fifo_level: AFULL_LEVEL must lie in 1..DEPTH");
    end
    if (AEMPTY_LEVEL >= DEPTH) begin : g_bad_aempty
        $error("fifo_level: AEMPTY_LEVEL must be below DEPTH");
    end

    logic [ADDR_BITS-1:0]  wptr_q,  wptr_d;
    logic [ADDR_BITS-1:0]  rptr_q,  rptr_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    fifo_flags_t           flags_q, flags_d;

    logic do_wr_c;
    logic do_rd_c;
    logic mem_we_c;

    // A write into a full queue is still accepted when a read frees the head slot.
    assign do_wr_c = write_i & (~flags_q.full | read_i);
    assign do_rd_c = read_i & ~flags_q.empty;

    // Next-state pointers, level and flags; flags follow the next level so they
    // change on the same edge as the pointers.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        flags_d  = flags_q;
        mem_we_c = 1'b0;

        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            flags_d = FLAGS_RESET;
        end else begin
            if (do_wr_c) begin
                mem_we_c = 1'b1;
                wptr_d   = wptr_q + ADDR_BITS'(1);
            end
            if (do_rd_c) begin
                rptr_d = rptr_q + ADDR_BITS'(1);
            end

            level_d = level_q + LEVEL_BITS'(do_wr_c) - LEVEL_BITS'(do_rd_c);

            flags_d.full      = (level_d == LEVEL_BITS'(DEPTH));
            flags_d.empty     = (level_d == '0);
            flags_d.afull     = (level_d >= LEVEL_BITS'(AFULL_LEVEL));
            flags_d.aempty    = (level_d <= LEVEL_BITS'(AEMPTY_LEVEL));
            flags_d.overflow  = flags_q.overflow  | (write_i & flags_q.full & ~read_i);
            flags_d.underflow = flags_q.underflow | (read_i & flags_q.empty);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            flags_q <= FLAGS_RESET;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            flags_q <= flags_d;
        end
    end

    fifo_mem #(
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_c),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (rdata_o)
    );

    assign level_o     = level_q;
    assign full_o      = flags_q.full;
    assign empty_o     = flags_q.empty;
    assign afull_o     = flags_q.afull;
    assign aempty_o    = flags_q.aempty;
    assign overflow_o  = flags_q.overflow;
    assign underflow_o = flags_q.underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Directed testbench for fifo_level (default parameters: 8-bit words, depth 16,
// almost-full at 12, almost-empty at 2).
module tb_fifo_level;

    logic       clk_i;
    logic       reset_ni;
    logic       clear_i;
    logic       write_i;
    logic [7:0] wdata_i;
    logic       read_i;
    logic [7:0] rdata_o;
    logic       full_o;
    logic       empty_o;
    logic       afull_o;
    logic       aempty_o;
    logic [4:0] level_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_checks = 0;
    int n_errors = 0;

    fifo_level dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .clear_i     (clear_i),
        .write_i     (write_i),
        .wdata_i     (wdata_i),
        .read_i      (read_i),
        .rdata_o     (rdata_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .afull_o     (afull_o),
        .aempty_o    (aempty_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full status check for a given expected occupancy and sticky flags.
    task automatic chk_state(input string tag, input int lvl, input logic ovf, input logic unf);
        chk({tag, ".level"},     32'(level_o),     32'(lvl));
        chk({tag, ".empty"},     32'(empty_o),     32'(lvl == 0));
        chk({tag, ".full"},      32'(full_o),      32'(lvl == 16));
        chk({tag, ".afull"},     32'(afull_o),     32'(lvl >= 12));
        chk({tag, ".aempty"},    32'(aempty_o),    32'(lvl <= 2));
        chk({tag, ".overflow"},  32'(overflow_o),  32'(ovf));
        chk({tag, ".underflow"}, 32'(underflow_o), 32'(unf));
    endtask

    // One clock cycle with the given request pattern; returns 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        write_i = wr;
        wdata_i = d;
        read_i  = rd;
        clear_i = clr;
        @(posedge clk_i);
        #1;
        write_i = 1'b0;
        read_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    logic [7:0] sb[$];
    logic [7:0] exp_d;

    initial begin
        reset_ni = 1'b0;
        clear_i  = 1'b0;
        write_i  = 1'b0;
        wdata_i  = 8'h00;
        read_i   = 1'b0;

        // 1 Reset
        repeat (2) @(posedge clk_i);
        #1;
        chk_state("in_reset", 0, 1'b0, 1'b0);
        reset_ni = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("after_reset", 0, 1'b0, 1'b0);

        // 2 Fill 0x01..0x10, then overflow
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk_state($sformatf("fill%0d", i), i, 1'b0, 1'b0);
            chk("fill.head", 32'(rdata_o), 32'h01);
        end
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_state("overflow", 16, 1'b1, 1'b0);
        chk("overflow.head", 32'(rdata_o), 32'h01);

        // 3 Drain in order, then underflow
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d.rdata", i), 32'(rdata_o), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk_state($sformatf("drain%0d", i), 16 - i, 1'b1, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("underflow", 0, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("clear1", 0, 1'b0, 1'b0);

        // 4 Simultaneous read/write at full and at empty
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        end
        chk_state("refill", 16, 1'b0, 1'b0);
        chk("refill.head", 32'(rdata_o), 32'h01);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk_state("full_rw", 16, 1'b0, 1'b0);
        chk("full_rw.head", 32'(rdata_o), 32'h02);
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'(i + 2) : 8'hAA;
            chk($sformatf("full_rw_drain%0d", i), 32'(rdata_o), 32'(exp_d));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_state("full_rw_drained", 0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk_state("empty_rw", 1, 1'b0, 1'b1);
        chk("empty_rw.head", 32'(rdata_o), 32'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("clear2", 0, 1'b0, 1'b0);

        // 5 Pointer wrap at constant level 3
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
            sb.push_back(8'(8'h30 + k));
        end
        chk_state("wrap_start", 3, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_d = sb.pop_front();
            chk($sformatf("wrap%0d.rdata", i), 32'(rdata_o), 32'(exp_d));
            cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            sb.push_back(8'(8'h80 + i));
            chk($sformatf("wrap%0d.level", i), 32'(level_o), 32'd3);
        end
        chk_state("wrap_end", 3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_d = sb.pop_front();
            chk($sformatf("wrap_drain%0d", k), 32'(rdata_o), 32'(exp_d));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_state("wrap_drained", 0, 1'b0, 1'b0);

        // 6 Flush with concurrent write at level 5, flags cleared
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("pre_flush_unf", 0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
        end
        chk_state("pre_flush", 5, 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_state("flush", 0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("flush_hold", 0, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_flush.head", 32'(rdata_o), 32'h77);

        // Asynchronous reset in the middle of a write burst
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        cyc(1'b1, 8'h79, 1'b0, 1'b0);
        chk_state("burst", 3, 1'b0, 1'b0);
        write_i = 1'b1;
        wdata_i = 8'h7A;
        #2;
        reset_ni = 1'b0;
        #1;
        chk_state("async_reset", 0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        chk_state("reset_held", 0, 1'b0, 1'b0);
        write_i  = 1'b0;
        reset_ni = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("reset_released", 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
